seq_shift_unit: RTL and testbench

- Multi-cycle, parametrised shift unit for the ALU; replaces the single-mode, combinational left-shift block.
- Supports four modes: LSL, LSR, ASR and ROR, at any operand width.
- Shifts by up to STEP bits per clock, trading latency for area.
- Uses a start/busy/done handshake, so the control unit can stall while the shift completes.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 46 ++++
 rtl/seq_shift_unit.sv | 110 +++++++++++
 tb/tb_seq_shift_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift unit: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of k bits (k >= 1 when used) in any of the four modes.
// Zero latency; no handshake, the caller sequences steps.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] t,
  input  op_e              op,
  input  logic [SHAMT_W:0] k,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  localparam logic [SHAMT_W:0] WK = (SHAMT_W + 1)'(WIDTH);

  // Extended vectors catch the last bit shifted out in the extra position.
  logic [WIDTH:0]        lsl_ext;
  logic [WIDTH:0]        lsr_ext;
  logic signed [WIDTH:0] asr_in;
  logic [WIDTH:0]        asr_ext;
  logic [WIDTH-1:0]      ror_res;

  assign lsl_ext = {1'b0, t} << k;
  assign lsr_ext = {t, 1'b0} >> k;
  assign asr_in  = {t, 1'b0};
  assign asr_ext = asr_in >>> k;
  assign ror_res = (t >> k) | (t << (WK - k));

  always_comb begin
    res   = t;
    carry = 1'b0;
    case (op)
      OP_LSL: {carry, res} = lsl_ext;
      OP_LSR: {res, carry} = lsr_ext;
      OP_ASR: {res, carry} = asr_ext;
      OP_ROR: begin
        res   = ror_res;
        carry = ror_res[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR unit shifting up to STEP bits per clock.
// Latency 1+ceil(n/STEP) cycles from accepted start to done; start ignored unless IDLE.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   Rin,
  input  logic [SHAMT_W-1:0] n,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Rx,
  output logic               carry_out
);

  localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W + 1)'(STEP);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   temp_q, temp_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               carry_q, carry_d;

  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   k;
  logic [WIDTH-1:0]   step_res;
  logic               step_carry;

  // STEP may equal WIDTH, so the clamp is done one bit wider than the counter.
  assign rem_ext = {1'b0, rem_q};
  assign k       = (rem_ext > STEP_K) ? STEP_K : rem_ext;

  shift_step #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_step (
    .t    (temp_q),
    .op   (op_q),
    .k    (k),
    .res  (step_res),
    .carry(step_carry)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    temp_d  = temp_q;
    rem_d   = rem_q;
    rx_d    = rx_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          temp_d = Rin;
          op_d   = op_e'(op);
          rem_d  = n;
          if (n != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            rx_d    = Rin;
            carry_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        temp_d = step_res;
        rem_d  = rem_q - k[SHAMT_W-1:0];
        if (k == rem_ext) begin
          state_d = DONE;
          rx_d    = step_res;
          carry_d = step_carry;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LSL;
      temp_q  <= '0;
      rem_q   <= '0;
      rx_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      temp_q  <= temp_d;
      rem_q   <= rem_d;
      rx_q    <= rx_d;
      carry_q <= carry_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign Rx        = rx_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: a STEP=1 and a STEP=4 instance driven from vector tables,
// random ops against a whole-shift reference model, and hand-written handshake/reset sequences.
module tb_seq_shift_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s1, s4;
  logic [1:0]  op1, op4;
  logic [31:0] rin1, rin4;
  logic [4:0]  n1, n4;
  logic        busy1, busy4, done1, done4, c1, c4;
  logic [31:0] rx1, rx4;

  seq_shift_unit #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .op(op1), .Rin(rin1), .n(n1),
    .busy(busy1), .done(done1), .Rx(rx1), .carry_out(c1)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .op(op4), .Rin(rin4), .n(n4),
    .busy(busy4), .done(done4), .Rx(rx4), .carry_out(c4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] rx;
    logic        c;
    int          lat;
  } exp_t;

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic [31:0] rin;
    int          n;
    logic [31:0] rx;
    logic        c;
    int          lat;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 4) ? done4 : done1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 4) ? busy4 : busy1;
  endfunction

  function automatic logic [31:0] get_rx(input int sel);
    return (sel == 4) ? rx4 : rx1;
  endfunction

  function automatic logic get_c(input int sel);
    return (sel == 4) ? c4 : c1;
  endfunction

  // Whole-shift reference: the result of shifting by n at once, last bit out as carry.
  function automatic exp_t model(input int sel, input logic [1:0] op, input logic [31:0] rin, input int n);
    exp_t e;
    int   stp;
    stp   = (sel == 4) ? 4 : 1;
    e.lat = 1 + (n + stp - 1) / stp;
    e.rx  = rin;
    e.c   = 1'b0;
    if (n != 0) begin
      case (op)
        2'd0: begin e.rx = rin << n; e.c = rin[32-n]; end
        2'd1: begin e.rx = rin >> n; e.c = rin[n-1]; end
        2'd2: begin e.rx = $signed(rin) >>> n; e.c = rin[n-1]; end
        default: begin e.rx = (rin >> n) | (rin << (32 - n)); e.c = e.rx[31]; end
      endcase
    end
    return e;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [1:0] op, input logic [31:0] rin, input int n);
    if (sel == 4) begin
      s4 = st; op4 = op; rin4 = rin; n4 = 5'(n);
    end else begin
      s1 = st; op1 = op; rin1 = rin; n1 = 5'(n);
    end
  endtask

  task automatic run(input int sel, input logic [1:0] op, input logic [31:0] rin, input int n,
                     input exp_t e, input string name);
    int   t0;
    logic got;
    exp_t q;
    @(negedge clk);
    drive(sel, 1'b1, op, rin, n);
    t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    drive(sel, 1'b0, 2'd0, 32'h0, 0);
    chk({name, "/busy"}, 32'(get_busy(sel)), 32'(n != 0));
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (get_done(sel)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "/done_seen"}, 32'(got), 32'd1);
    q = sbq.pop_front();
    chk({name, "/latency"}, 32'(cyc - t0), 32'(q.lat));
    chk({name, "/Rx"}, get_rx(sel), q.rx);
    chk({name, "/carry"}, 32'(get_c(sel)), 32'(q.c));
    @(negedge clk);
    chk({name, "/done_pulse"}, 32'(get_done(sel)), 32'd0);
  endtask

  initial begin
    exp_t        e;
    int          t0, dcount, dcyc;
    logic [31:0] cap_rx;
    logic        cap_c;
    logic [1:0]  rop;
    logic [31:0] rrin;
    int          rn, rsel;

    tbl[0]  = '{1, 2'd0, 32'h0000_0001, 31, 32'h8000_0000, 1'b0, 32};
    tbl[1]  = '{1, 2'd0, 32'hFFFF_FFFF,  4, 32'hFFFF_FFF0, 1'b1,  5};
    tbl[2]  = '{1, 2'd2, 32'h8000_0000,  4, 32'hF800_0000, 1'b0,  5};
    tbl[3]  = '{1, 2'd1, 32'h8000_0000,  4, 32'h0800_0000, 1'b0,  5};
    tbl[4]  = '{1, 2'd3, 32'h0000_0001,  1, 32'h8000_0000, 1'b1,  2};
    tbl[5]  = '{1, 2'd3, 32'h1234_5678,  0, 32'h1234_5678, 1'b0,  1};
    tbl[6]  = '{4, 2'd1, 32'h1234_5678,  0, 32'h1234_5678, 1'b0,  1};
    tbl[7]  = '{4, 2'd0, 32'h0000_00FF,  5, 32'h0000_1FE0, 1'b0,  3};
    tbl[8]  = '{4, 2'd3, 32'h0000_000F,  4, 32'hF000_0000, 1'b1,  2};
    tbl[9]  = '{4, 2'd2, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0,  9};
    tbl[10] = '{4, 2'd1, 32'hA500_0000, 25, 32'h0000_0052, 1'b1,  8};
    tbl[11] = '{1, 2'd0, 32'h0000_0003, 31, 32'h8000_0000, 1'b1, 32};

    rst_n = 1'b0;
    drive(1, 1'b0, 2'd0, 32'h0, 0);
    drive(4, 1'b0, 2'd0, 32'h0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset/busy1", 32'(busy1), 32'd0);
    chk("reset/done1", 32'(done1), 32'd0);
    chk("reset/Rx1", rx1, 32'h0);
    chk("reset/carry1", 32'(c1), 32'd0);
    chk("reset/busy4", 32'(busy4), 32'd0);
    chk("reset/Rx4", rx4, 32'h0);

    for (int i = 0; i < 12; i++) begin
      e.rx = tbl[i].rx; e.c = tbl[i].c; e.lat = tbl[i].lat;
      run(tbl[i].sel, tbl[i].op, tbl[i].rin, tbl[i].n, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      rsel = (i % 2 == 0) ? 4 : 1;
      rop  = 2'($urandom_range(0, 3));
      rrin = $urandom;
      rn   = $urandom_range(0, 31);
      run(rsel, rop, rrin, rn, model(rsel, rop, rrin, rn), $sformatf("rnd%0d", i));
    end

    // start pulsed mid-shift must be dropped without disturbing the first operation
    @(negedge clk);
    drive(1, 1'b1, 2'd0, 32'h0000_1ABC, 20);
    t0 = cyc;
    e.rx = 32'hABC0_0000; e.c = 1'b1; e.lat = 21;
    sbq.push_back(e);
    dcount = 0; dcyc = 0; cap_rx = '0; cap_c = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc == t0 + 5) drive(1, 1'b1, 2'd1, 32'hFFFF_FFFF, 3);
      else drive(1, 1'b0, 2'd0, 32'h0, 0);
      if (done1) begin
        dcount++;
        if (dcount == 1) begin
          dcyc = cyc; cap_rx = rx1; cap_c = c1;
        end
      end
    end
    e = sbq.pop_front();
    chk("ignore/done_count", 32'(dcount), 32'd1);
    chk("ignore/latency", 32'(dcyc - t0), 32'(e.lat));
    chk("ignore/Rx", cap_rx, e.rx);
    chk("ignore/carry", 32'(cap_c), 32'(e.c));

    // reset mid-shift discards the operation
    @(negedge clk);
    drive(1, 1'b1, 2'd0, 32'h0000_0001, 20);
    t0 = cyc;
    @(negedge clk);
    drive(1, 1'b0, 2'd0, 32'h0, 0);
    while (cyc < t0 + 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset/busy", 32'(busy1), 32'd0);
    chk("midreset/done", 32'(done1), 32'd0);
    chk("midreset/Rx", rx1, 32'h0);
    chk("midreset/carry", 32'(c1), 32'd0);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1) dcount++;
    end
    chk("midreset/no_done", 32'(dcount), 32'd0);
    e.rx = 32'h8000_0001; e.c = 1'b1; e.lat = 3;
    run(1, 2'd3, 32'h0000_0006, 2, e, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
